// File: rtl/ef_smsdac_pkg.sv
// Shared constants, types and helpers for the
// mismatch-shaping DAC segment decoder/monitor.
package ef_smsdac_pkg;

  localparam int NSEG      = 8;
  localparam int CODE_W    = 9;
  localparam int IMB_W     = 6;
  localparam int IMB_BOUND = 2;
  localparam int CNT_W     = 16;

  typedef logic [1:0] seg_t;

  typedef struct packed {
    logic              v;
    seg_t [NSEG-1:0]   y;
    logic [CODE_W-1:0] ref_code;
  } st1_t;

  function automatic int unsigned seg_weight(
    input int   k,
    input seg_t sel
  );
    int unsigned cnt;
    cnt = int'(sel[0]) + int'(sel[1]);
    return cnt << k;
  endfunction

endpackage

// File: rtl/ef_smsdac_msd_seg.sv
// Per-segment element-usage imbalance tracker
// with saturation and sticky shaping-violation flag.
module ef_smsdac_msd_seg
  import ef_smsdac_pkg::*;
#(
  parameter int W     = IMB_W,
  parameter int BOUND = IMB_BOUND
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en_shape,
  input  logic in_valid,
  input  seg_t sel,
  output logic flag
);

  localparam logic signed [W-1:0] SMAX =
    W'((2 ** (W - 1)) - 1);
  localparam logic signed [W-1:0] SBND =
    W'(BOUND);

  logic signed [W-1:0] acc;
  logic signed [W-1:0] nxt;
  logic                inc;
  logic                dec;
  logic                over;

  assign inc = (sel == 2'b10);
  assign dec = (sel == 2'b01);

  // next accumulator value, clamped at +/-SMAX
  always_comb begin
    nxt = acc;
    unique case (1'b1)
      inc: if (acc != SMAX) nxt = acc + 1'b1;
      dec: if (acc != -SMAX) nxt = acc - 1'b1;
      default: nxt = acc;
    endcase
  end

  assign over = (nxt > SBND) || (nxt < -SBND);

  // accumulate while armed; flag sticks on overflow
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc  <= '0;
      flag <= 1'b0;
    end else if (in_valid && en_shape) begin
      acc <= nxt;
      if (over) flag <= 1'b1;
    end
  end

endmodule

// File: rtl/ef_smsdac_msd.sv
// Segment decoder/monitor: rebuilds the DAC code,
// checks it against a reference, tracks imbalance.
module ef_smsdac_msd
  import ef_smsdac_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en_shape,
  input  logic                in_valid,
  input  logic [2*NSEG-1:0]   y,
  input  logic [CODE_W-1:0]   code_ref,
  output logic                dec_valid,
  output logic [CODE_W-1:0]   dec_code,
  output logic                code_err,
  output logic [NSEG-1:0]     imb_flag,
  output logic [CNT_W-1:0]    err_cnt,
  output logic [CNT_W-1:0]    sample_cnt
);

  st1_t              s1;
  logic [CODE_W-1:0] sum;

  // stage 1: capture the accepted sample
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
    end else begin
      s1.v <= in_valid;
      if (in_valid) begin
        s1.y        <= y;
        s1.ref_code <= code_ref;
      end
    end
  end

  // weighted element count across all segments
  always_comb begin
    sum = '0;
    for (int k = 0; k < NSEG; k++) begin
      sum = sum + CODE_W'(seg_weight(k, s1.y[k]));
    end
  end

  // stage 2: registered decode and compare
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_valid <= 1'b0;
      dec_code  <= '0;
      code_err  <= 1'b0;
    end else begin
      dec_valid <= s1.v;
      code_err  <= s1.v && (sum != s1.ref_code);
      if (s1.v) dec_code <= sum;
    end
  end

  // saturating counters; clr beats same-cycle events
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
    end else begin
      if (in_valid && (sample_cnt != '1))
        sample_cnt <= sample_cnt + 1'b1;
      if (code_err && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    ef_smsdac_msd_seg u_seg (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .en_shape (en_shape),
      .in_valid (in_valid),
      .sel      (y[2*k +: 2]),
      .flag     (imb_flag[k])
    );
  end

endmodule
